flash_sample_ctrl: RTL
======================

# flash_sample_ctrl

Sequences 32-bit reads from the on-board flash through an Avalon-MM style read port and delivers one 16-bit audio sample per sample tick. It owns the flash read handshake and the playback position: forward or backward, pause, restart, and wrap within a configured word range. It sits between the flash controller and the audio output path, and replaces free-running address stepping with a demand-driven scheduler.

## Interface
- ADDR_W, 23, flash word-address width
- START_ADDR, 0, first word of playback range
- END_ADDR, 23'h7FFFF, last word of playback range (inclusive, END_ADDR >= START_ADDR)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sample_tick  in  1  one-cycle pulse, already synchronous to clk, requests one sample
- play  in  1  1 = service ticks, 0 = pause (ticks ignored)
- dir  in  1  0 = forward, 1 = backward
- restart  in  1  one-cycle pulse, jump to range start (forward) or end (backward)
- flash_read  out  1  read request
- flash_addr  out  ADDR_W  word address
- flash_waitrequest  in  1  request not yet accepted
- flash_readdata  in  32  read word
- flash_readdatavalid  in  1  readdata valid this cycle
- sample_out  out  16  current sample, held between updates
- sample_valid  out  1  one-cycle pulse, sample_out updated
- busy  out  1  state != IDLE
- overrun  out  1  sticky: tick arrived while busy
- loop_pulse  out  1  one-cycle pulse when position crosses the range boundary

## Operation
- Position = {word addr, half}. half 0 = readdata[15:0], half 1 = readdata[31:16]. A one-word buffer (buf_word, buf_valid) holds the last fetched word.
- States: IDLE, FETCH, WAIT, EMIT.
- IDLE: on sample_tick && play: if buf_valid -> EMIT, else -> FETCH. A tick with play=0 does nothing.
- FETCH: flash_read=1, flash_addr=addr, both held stable; when flash_waitrequest=0 -> WAIT.
- WAIT: on flash_readdatavalid, capture buf_word and set buf_valid -> EMIT.
- EMIT: sample_out <= selected half, sample_valid=1; step position by one sample using dir sampled this cycle -> IDLE.
- Forward step: half0->half1; half1->addr+1, half0. Backward step: half1->half0; half0->addr-1, half1. buf_valid is cleared whenever addr changes.
- Wrap: forward from END_ADDR/half1 -> START_ADDR/half0; backward from START_ADDR/half0 -> END_ADDR/half1; loop_pulse asserted in the EMIT cycle.
- Tick while busy: tick dropped, overrun set.
- restart in IDLE: position <= dir ? END_ADDR/half1 : START_ADDR/half0; buf_valid=0; overrun cleared.
- restart in FETCH/WAIT: latched; the transaction completes (never abandon an accepted or pending read); the data is discarded with no sample_valid; restart applied on return to IDLE.
- restart in EMIT: the sample emits, then restart overrides the step.
- Reset: state IDLE, position START_ADDR/half0, buf_valid 0, flash_read 0, flash_addr START_ADDR, sample_out 0, all pulses/flags 0.

## Timing
- Buffered sample: tick in cycle t -> sample_valid in t+1.
- Fetched sample: tick at t, FETCH t+1; with waitrequest=0 and readdatavalid at t+2, sample_valid at t+3. Each extra waitrequest or latency cycle adds one.
- flash_addr is registered; flash_read deasserts in the cycle after acceptance.
- Every output is registered.

## Configuration
- FLASH_SAMPLE_CTRL_WRAP_EN defined: wrap at the range boundary as above.
- Undefined: at the boundary, emit the final sample, pulse loop_pulse, then ignore all ticks (no overrun) until restart.

## Structure
- flash_ctrl_pkg: state enum, HALF_LO/HALF_HI constants, and the position struct {addr, half}.
- Sub-module sample_pos_step: combinational next position plus wrap flag from (pos, dir, START_ADDR, END_ADDR).

## Test plan
- Forward from reset, readdata 32'hBBBBAAAA then 32'hDDDDCCCC, 4 ticks -> samples AAAA, BBBB, CCCC, DDDD; 2 flash reads at addr 0, 1.
- dir=1 after restart, END_ADDR word 32'h22221111 -> samples 2222 then 1111; next read at END_ADDR-1.
- waitrequest held 3 cycles, readdatavalid 2 cycles later -> flash_addr stable throughout; sample_valid exactly 1 cycle after capture; second tick during WAIT -> overrun=1.
- Forward at END_ADDR/half1 -> loop_pulse; next read at START_ADDR (WRAP_EN), or no further reads (not defined).
- restart pulsed during WAIT -> no sample_valid; next tick reads START_ADDR.
- rst asserted mid-FETCH -> flash_read drops asynchronously; all outputs at reset values.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// Shared types for the flash sample controller.
//   state_t   : controller states (IDLE, FETCH, WAIT, EMIT)
//   HALF_LO/HI: which 16-bit half of a flash word is the current sample
//   pos_t     : playback position {word address, half}
package flash_ctrl_pkg;

  localparam int unsigned POS_ADDR_W = 23;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT
  } state_t;

  typedef struct packed {
    logic [POS_ADDR_W-1:0] addr;
    logic                  half;
  } pos_t;

endpackage

// File: rtl/sample_pos_step.sv
// Combinational one-sample step of the playback position.
//   pos      : current position
//   dir      : 0 = forward, 1 = backward
//   next_pos : position after one sample step (wrapped at the range ends)
//   wrap     : the step crosses the START_ADDR/END_ADDR boundary
module sample_pos_step
  import flash_ctrl_pkg::*;
#(
  parameter logic [POS_ADDR_W-1:0] START_ADDR = '0,
  parameter logic [POS_ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
  input  pos_t pos,
  input  logic dir,
  output pos_t next_pos,
  output logic wrap
);

  always_comb begin
    next_pos = pos;
    wrap     = 1'b0;
    if (!dir) begin
      if (pos.half == HALF_LO) begin
        next_pos.half = HALF_HI;
      end else if (pos.addr == END_ADDR) begin
        next_pos.addr = START_ADDR;
        next_pos.half = HALF_LO;
        wrap          = 1'b1;
      end else begin
        next_pos.addr = pos.addr + POS_ADDR_W'(1);
        next_pos.half = HALF_LO;
      end
    end else begin
      if (pos.half == HALF_HI) begin
        next_pos.half = HALF_LO;
      end else if (pos.addr == START_ADDR) begin
        next_pos.addr = END_ADDR;
        next_pos.half = HALF_HI;
        wrap          = 1'b1;
      end else begin
        next_pos.addr = pos.addr - POS_ADDR_W'(1);
        next_pos.half = HALF_HI;
      end
    end
  end

endmodule

// File: rtl/flash_sample_ctrl.sv
// Demand-driven flash sample scheduler: one 16-bit sample per sample_tick,
// fetched as 32-bit words over an Avalon-MM style read port, with a one-word
// buffer, forward/backward playback, pause, restart and range wrap.
// Configuration macro FLASH_SAMPLE_CTRL_WRAP_EN: defined = wrap at the range
// boundary; undefined = stop after the boundary sample until restart.
// Ports:
//   clk, rst (async, active-high)
//   sample_tick, play, dir, restart          : playback control
//   flash_read/addr/waitrequest/readdata/
//   flash_readdatavalid                      : flash read port
//   sample_out, sample_valid                 : sample output
//   busy, overrun, loop_pulse                : status
module flash_sample_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = POS_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              dir,
  input  logic              restart,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun,
  output logic              loop_pulse
);

`ifdef FLASH_SAMPLE_CTRL_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [POS_ADDR_W-1:0] START_POS = POS_ADDR_W'(START_ADDR);
  localparam logic [POS_ADDR_W-1:0] END_POS   = POS_ADDR_W'(END_ADDR);

  state_t      state, state_next;
  pos_t        pos, step_pos, restart_pos;
  logic        step_wrap;
  logic [31:0] buf_word;
  logic        buf_valid;
  logic        restart_pend;
  logic        halted;
  logic        restart_req, apply_restart, enter_emit;
  logic [15:0] emit_half;

  sample_pos_step #(
    .START_ADDR(START_POS),
    .END_ADDR  (END_POS)
  ) u_step (
    .pos     (pos),
    .dir     (dir),
    .next_pos(step_pos),
    .wrap    (step_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Outputs are registered, so the sample, its position step and loop_pulse
  // are all computed on the transition into EMIT; EMIT itself only returns
  // to IDLE (or applies a restart that overrides the step just taken).
  always_comb begin
    state_next  = state;
    restart_req = restart | restart_pend;
    restart_pos.addr = dir ? END_POS : START_POS;
    restart_pos.half = dir ? HALF_HI : HALF_LO;
    unique case (state)
      IDLE:  if (!restart_req && sample_tick && play && !halted)
               state_next = buf_valid ? EMIT : FETCH;
      FETCH: if (!flash_waitrequest) state_next = WAIT;
      WAIT:  if (flash_readdatavalid) state_next = restart_req ? IDLE : EMIT;
      EMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    enter_emit    = (state_next == EMIT) && (state != EMIT);
    apply_restart = restart_req && ((state == IDLE) || (state == EMIT) ||
                    ((state == WAIT) && flash_readdatavalid));
    if (state == WAIT)
      emit_half = (pos.half == HALF_HI) ? flash_readdata[31:16] : flash_readdata[15:0];
    else
      emit_half = (pos.half == HALF_HI) ? buf_word[31:16] : buf_word[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos          <= '{addr: START_POS, half: HALF_LO};
      buf_word     <= '0;
      buf_valid    <= 1'b0;
      restart_pend <= 1'b0;
      halted       <= 1'b0;
      flash_read   <= 1'b0;
      flash_addr   <= START_ADDR;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      loop_pulse   <= 1'b0;
    end else begin
      sample_valid <= enter_emit;
      loop_pulse   <= enter_emit && step_wrap;
      busy         <= (state_next != IDLE);
      if (sample_tick && (state != IDLE) && !halted) overrun <= 1'b1;
      if (restart) restart_pend <= 1'b1;

      unique case (state)
        IDLE: if (state_next == FETCH) begin
          flash_read <= 1'b1;
          flash_addr <= ADDR_W'(pos.addr);
        end
        FETCH: if (!flash_waitrequest) flash_read <= 1'b0;
        WAIT: if (flash_readdatavalid) begin
          buf_word  <= flash_readdata;
          buf_valid <= 1'b1;
        end
        default: ;
      endcase

      if (enter_emit) begin
        sample_out <= emit_half;
        if (step_wrap && !WRAP_EN) begin
          halted <= 1'b1;
        end else begin
          pos <= step_pos;
          if (step_pos.addr != pos.addr) buf_valid <= 1'b0;
        end
      end

      // A pending restart lands only once no read is outstanding; a read in
      // flight is always allowed to complete and its data is dropped.
      if (apply_restart) begin
        pos          <= restart_pos;
        buf_valid    <= 1'b0;
        overrun      <= 1'b0;
        halted       <= 1'b0;
        restart_pend <= 1'b0;
      end
    end
  end

endmodule
